// File: rtl/dac_spi_tx.sv
// dac_spi_tx: shifts one 12-bit sample per valid/ready handshake out to a
// DAC121S101-style SPI DAC as a 16-bit MSB-first frame {2'b00, PD_MODE, sample}.
// SCLK idles high; sdata changes on SCLK rising edges so the DAC can sample
// on falling edges. All outputs are registered.
module dac_spi_tx #(
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned GAP_CYCLES = 4,
    parameter logic [1:0]  PD_MODE    = 2'b00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] value_in,
    input  logic        valid,
    output logic        ready,
    output logic        done,
    output logic        sclk,
    output logic        sync_n,
    output logic        sdata
);

    localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [15:0]   shreg_q, shreg_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic          sclk_q, sclk_d;
    logic          sync_n_q, sync_n_d;
    logic          sdata_q, sdata_d;
    logic          ready_q, ready_d;
    logic          done_q, done_d;

    logic [15:0]   frame;

    assign frame = {2'b00, PD_MODE, value_in};

    // State and output registers; reset parks the bus idle (sclk/sync_n high).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            div_cnt_q <= '0;
            gap_cnt_q <= '0;
            sclk_q    <= 1'b1;
            sync_n_q  <= 1'b1;
            sdata_q   <= 1'b0;
            ready_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            div_cnt_q <= div_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            sclk_q    <= sclk_d;
            sync_n_q  <= sync_n_d;
            sdata_q   <= sdata_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
        end
    end

    // Next-state logic: accept, per-bit sclk high/low phases, frame end, gap.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        div_cnt_d = div_cnt_q;
        gap_cnt_d = gap_cnt_q;
        sclk_d    = sclk_q;
        sync_n_d  = sync_n_q;
        sdata_d   = sdata_q;
        ready_d   = ready_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                ready_d  = 1'b1;
                sclk_d   = 1'b1;
                sync_n_d = 1'b1;
                // ready_q gates accept so the first cycle after reset never accepts.
                if (valid && ready_q) begin
                    shreg_d   = frame;
                    sdata_d   = frame[15];
                    sync_n_d  = 1'b0;
                    ready_d   = 1'b0;
                    bit_cnt_d = '0;
                    div_cnt_d = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    if (sclk_q) begin
                        // End of high phase: falling edge, DAC samples sdata.
                        sclk_d = 1'b0;
                    end else if (bit_cnt_q == 4'd15) begin
                        // Last low phase done: close the frame.
                        sclk_d    = 1'b1;
                        sync_n_d  = 1'b1;
                        sdata_d   = 1'b0;
                        done_d    = 1'b1;
                        gap_cnt_d = '0;
                        state_d   = GAP;
                    end else begin
                        // Rising edge: advance to the next bit.
                        sclk_d    = 1'b1;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        shreg_d   = {shreg_q[14:0], 1'b0};
                        sdata_d   = shreg_q[14];
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    ready_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ready  = ready_q;
    assign done   = done_q;
    assign sclk   = sclk_q;
    assign sync_n = sync_n_q;
    assign sdata  = sdata_q;

endmodule

// File: tb/tb_dac_spi_tx.sv
// Bench for dac_spi_tx: a default instance (CLK_DIV=2, GAP=4) and a fast
// instance (CLK_DIV=1, GAP=1, PD_MODE=11). A cycle-sampled SPI model captures
// bits on sclk falling edges while sync_n is low.
module tb_dac_spi_tx;

    localparam int CA = 2;
    localparam int GA = 4;
    localparam int CB = 1;
    localparam int GB = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] value_in = 12'h000;
    logic        valid_a = 1'b0;
    logic        valid_b = 1'b0;
    logic        ready_a, done_a, sclk_a, sync_n_a, sdata_a;
    logic        ready_b, done_b, sclk_b, sync_n_b, sdata_b;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    logic sel = 1'b0;

    logic m_ready, m_done, m_sclk, m_sync_n, m_sdata;
    assign m_ready  = sel ? ready_b  : ready_a;
    assign m_done   = sel ? done_b   : done_a;
    assign m_sclk   = sel ? sclk_b   : sclk_a;
    assign m_sync_n = sel ? sync_n_b : sync_n_a;
    assign m_sdata  = sel ? sdata_b  : sdata_a;

    dac_spi_tx #(.CLK_DIV(CA), .GAP_CYCLES(GA), .PD_MODE(2'b00)) u_a (
        .clk(clk), .rst(rst), .value_in(value_in), .valid(valid_a),
        .ready(ready_a), .done(done_a), .sclk(sclk_a), .sync_n(sync_n_a), .sdata(sdata_a)
    );

    dac_spi_tx #(.CLK_DIV(CB), .GAP_CYCLES(GB), .PD_MODE(2'b11)) u_b (
        .clk(clk), .rst(rst), .value_in(value_in), .valid(valid_b),
        .ready(ready_b), .done(done_b), .sclk(sclk_b), .sync_n(sync_n_b), .sdata(sdata_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // sdata stability around falling edges and idle-bus checks on instance A.
    int   since_fall = 1000;
    int   since_chg  = 1000;
    int   viol6 = 0;
    int   violi = 0;
    logic p_sclk = 1'b1;
    logic p_sdata = 1'b0;
    logic p_sync = 1'b1;
    always @(negedge clk) begin
        since_fall <= (p_sclk && !sclk_a) ? 0 : since_fall + 1;
        since_chg  <= (sdata_a !== p_sdata) ? 0 : since_chg + 1;
        if (!rst && !sync_n_a && p_sclk && !sclk_a && ((sdata_a !== p_sdata) || (since_chg + 1 < CA)))
            viol6 <= viol6 + 1;
        if (!rst && !sync_n_a && !p_sync && (sdata_a !== p_sdata) &&
            ((p_sclk && !sclk_a) || (since_fall + 1 < CA)))
            viol6 <= viol6 + 1;
        if ((ready_a && !(sclk_a && sync_n_a)) || (ready_b && !(sclk_b && sync_n_b)))
            violi <= violi + 1;
        p_sclk  <= sclk_a;
        p_sdata <= sdata_a;
        p_sync  <= sync_n_a;
    end

    typedef struct {
        logic [11:0] val;
        logic [15:0] exp;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_valid(input logic v);
        if (sel) valid_b = v;
        else     valid_a = v;
    endtask

    // Call at a negedge. Raises valid, waits (bounded) for ready, returns 1 time
    // unit after the accepting edge with t0 = cycle count at that edge.
    task automatic accept(input logic [11:0] v, input string nm, output int t0);
        int w;
        w = 0;
        value_in = v;
        set_valid(1'b1);
        while (!m_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk({nm, " ready before accept"}, {31'd0, m_ready}, 32'd1);
        @(posedge clk);
        #1;
        t0 = cyc;
    endtask

    // Samples one frame from the negedge after the accept edge (j=0) through
    // the sample where ready should return (j=32C+G).
    task automatic watch(input logic [15:0] exp, input int c, input int g,
                         input int inj_j, input logic [11:0] inj_v, input string nm);
        logic [15:0] rx;
        int falls, low, hi_end, done_cnt, done_j, rdy_j;
        logic ps;
        rx = '0; falls = 0; low = 0; hi_end = 0; done_cnt = 0; done_j = -1; rdy_j = -1;
        ps = 1'b1;
        for (int j = 0; j <= 32*c + g; j++) begin
            @(negedge clk);
            if (inj_j >= 0 && j == inj_j) begin
                value_in = inj_v;
                set_valid(1'b1);
            end else if (inj_j >= 0 && j == inj_j + 1) begin
                set_valid(1'b0);
            end
            if (ps && !m_sclk && !m_sync_n) begin
                falls++;
                rx = {rx[14:0], m_sdata};
            end
            ps = m_sclk;
            if (!m_sync_n) low++;
            else if (j >= 32*c) hi_end++;
            if (m_done) begin
                done_cnt++;
                done_j = j;
            end
            if (m_ready && rdy_j < 0) rdy_j = j;
        end
        chk({nm, " frame"}, {16'd0, rx}, {16'd0, exp});
        chk({nm, " falls"}, falls, 16);
        chk({nm, " sync_n low cycles"}, low, 32*c);
        chk({nm, " done pulses"}, done_cnt, 1);
        chk({nm, " done offset"}, done_j, 32*c);
        chk({nm, " ready offset"}, rdy_j, 32*c + g);
        chk({nm, " sync_n high after frame"}, hi_end, g + 1);
    endtask

    vec_t vecs[5];
    int   t1, t2, lowcnt;

    initial begin
        vecs[0] = '{12'hABC, 16'h0ABC};
        vecs[1] = '{12'h000, 16'h0000};
        vecs[2] = '{12'hFFF, 16'h0FFF};
        vecs[3] = '{12'h555, 16'h0555};
        vecs[4] = '{12'hA5A, 16'h0A5A};

        // Reset with valid high: rst wins.
        valid_a = 1'b1;
        value_in = 12'h321;
        repeat (3) @(negedge clk);
        chk("reset outputs A", {27'd0, ready_a, done_a, sclk_a, sync_n_a, sdata_a}, 32'b00110);
        chk("reset outputs B", {27'd0, ready_b, done_b, sclk_b, sync_n_b, sdata_b}, 32'b00110);
        rst = 1'b0;
        valid_a = 1'b0;
        @(negedge clk);
        chk("ready after reset", {31'd0, ready_a}, 32'd1);
        chk("no accept during reset", {31'd0, sync_n_a}, 32'd1);

        // Table of single frames on instance A.
        sel = 1'b0;
        for (int i = 0; i < 5; i++) begin
            accept(vecs[i].val, $sformatf("vec%0d", i), t1);
            valid_a = 1'b0;
            watch(vecs[i].exp, CA, GA, -1, 12'h000, $sformatf("vec%0d", i));
        end

        // valid held: back-to-back frames; value_in changes right after accept.
        accept(12'h000, "hold1", t1);
        value_in = 12'hFFF;
        watch(16'h0000, CA, GA, -1, 12'h000, "hold1");
        accept(12'hFFF, "hold2", t2);
        valid_a = 1'b0;
        chk("hold period", t2 - t1, 32*CA + GA + 1);
        watch(16'h0FFF, CA, GA, -1, 12'h000, "hold2");

        // valid pulse mid-frame is ignored and not queued.
        accept(12'hABC, "ign", t1);
        valid_a = 1'b0;
        watch(16'h0ABC, CA, GA, 10, 12'h123, "ign");
        lowcnt = 0;
        for (int j = 0; j < 80; j++) begin
            @(negedge clk);
            if (!sync_n_a) lowcnt++;
        end
        chk("ignored valid no frame", lowcnt, 0);

        // Reset mid-frame, with valid high during reset.
        accept(12'hABC, "rstmid", t1);
        valid_a = 1'b0;
        for (int j = 0; j < 20; j++) @(negedge clk);
        rst = 1'b1;
        value_in = 12'h555;
        valid_a = 1'b1;
        @(negedge clk);
        chk("rstmid bus idle", {29'd0, sync_n_a, sclk_a, ready_a}, 32'b110);
        chk("rstmid no done", {31'd0, done_a}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid ready after release", {30'd0, ready_a, sync_n_a}, 32'b11);
        chk("rstmid no done after release", {31'd0, done_a}, 32'd0);
        accept(12'h555, "post_rst", t1);
        valid_a = 1'b0;
        watch(16'h0555, CA, GA, -1, 12'h000, "post_rst");

        // Fast instance: CLK_DIV=1, GAP=1, PD_MODE=11.
        sel = 1'b1;
        accept(12'h800, "fast1", t1);
        watch(16'h3800, CB, GB, -1, 12'h000, "fast1");
        accept(12'h800, "fast2", t2);
        valid_b = 1'b0;
        chk("fast period", t2 - t1, 34);
        watch(16'h3800, CB, GB, -1, 12'h000, "fast2");
        sel = 1'b0;

        @(negedge clk);
        chk("sdata stable around falling edges", viol6, 0);
        chk("idle bus while ready", violi, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
